// File: rtl/io_port_bank.sv
// io_port_bank
//   8086-style I/O peripheral with NUM_PORTS data ports of DATA_W bits,
//   decoded from the I/O window [BASE_ADDR, BASE_ADDR+NUM_PORTS).
//   The block only answers I/O cycles (IOM=1). It latches the port index on
//   ALE and holds READY low for WAIT_STATES cycles. A read registers PORT_IN
//   onto DOUT. A write registers DIN into PORT_OUT. There is no tri-state
//   inside the block: the bus driver outside it uses DOUT_EN.
//
// Ports
//   CLK, RESET      clock and synchronous active-high reset
//   ALE, IOM, ADDR  address phase: latch enable, I/O-vs-memory, address
//   RD_N, WR_N      active-low read and write strobes
//   DIN             write data from the CPU
//   DOUT, DOUT_EN   read data and its bus-drive enable
//   READY           0 = wait state requested
//   PORT_IN         read sources, port i at bits [i*DATA_W +: DATA_W]
//   PORT_OUT        write registers, same packing
module io_port_bank #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 20,
  parameter int                NUM_PORTS   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 20'h00040,
  parameter int                WAIT_STATES = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ALE,
  input  logic                        IOM,
  input  logic                        RD_N,
  input  logic                        WR_N,
  input  logic [ADDR_W-1:0]           ADDR,
  input  logic [DATA_W-1:0]           DIN,
  output logic [DATA_W-1:0]           DOUT,
  output logic                        DOUT_EN,
  output logic                        READY,
  input  logic [NUM_PORTS*DATA_W-1:0] PORT_IN,
  output logic [NUM_PORTS*DATA_W-1:0] PORT_OUT
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  // The window limits are held one bit wider than the address, so a window
  // that ends at the top of the address space does not wrap to zero.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(NUM_PORTS);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic                        op_rd;
  logic [3:0]                  wcnt;
  logic [DATA_W-1:0]           dout_r;
  logic                        dout_en_r;
  logic                        ready_r;
  logic [NUM_PORTS*DATA_W-1:0] port_out_r;

  logic              hit;
  logic [IDX_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] rd_sel;
  logic              strobe_hi;

  // Decode of the current bus address
  always_comb begin
    hit     = ({1'b0, ADDR} >= WIN_LO) && ({1'b0, ADDR} < WIN_HI);
    idx_nxt = IDX_W'(ADDR - BASE_ADDR);
  end

  // Read-source select by the latched index
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (idx == IDX_W'(i)) rd_sel = PORT_IN[i*DATA_W +: DATA_W];
    end
  end

  // The strobe that opened the current access has been released
  assign strobe_hi = op_rd ? RD_N : WR_N;

  // Bus cycle state machine; all outputs are registered here
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      idx        <= '0;
      op_rd      <= 1'b0;
      wcnt       <= '0;
      dout_r     <= '0;
      dout_en_r  <= 1'b0;
      ready_r    <= 1'b1;
      port_out_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // A strobe seen together with ALE is not acted on here. It is
          // evaluated from DECODE on the following cycle.
          if (ALE && IOM && hit) begin
            idx   <= idx_nxt;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (ALE && IOM) begin
            if (hit) idx   <= idx_nxt;
            else     state <= S_IDLE;
          end else if (!RD_N && !WR_N) begin
            state <= S_IDLE;
          end else if (!RD_N || !WR_N) begin
            op_rd <= !RD_N;
            if (WAIT_STATES == 0) begin
              state <= S_ACCESS;
            end else begin
              state   <= S_WAIT;
              ready_r <= 1'b0;
              wcnt    <= WS_LOAD;
            end
          end
        end

        S_WAIT: begin
          // An abort takes priority over the end of the wait count
          if (strobe_hi) begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
          end else if (wcnt == 4'd0) begin
            state   <= S_ACCESS;
            ready_r <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end

        S_ACCESS: begin
          if (op_rd) begin
            dout_r    <= rd_sel;
            dout_en_r <= 1'b1;
          end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
              if (idx == IDX_W'(i)) port_out_r[i*DATA_W +: DATA_W] <= DIN;
            end
          end
          state <= S_DONE;
        end

        S_DONE: begin
          // DOUT keeps its last value after the bus is released
          if (strobe_hi) begin
            dout_en_r <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign DOUT     = dout_r;
  assign DOUT_EN  = dout_en_r;
  assign READY    = ready_r;
  assign PORT_OUT = port_out_r;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank
//   Directed bench for io_port_bank. Instance a uses the default parameters.
//   Instance b uses WAIT_STATES=0, NUM_PORTS=8 and DATA_W=16.
module tb_io_port_bank;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  // instance a: defaults
  logic        ale, iom, rd_n, wr_n;
  logic [19:0] addr;
  logic [7:0]  din, dout;
  logic        dout_en, ready;
  logic [31:0] port_in, port_out;

  // instance b: WAIT_STATES=0, NUM_PORTS=8, DATA_W=16
  logic         b_ale, b_iom, b_rd_n, b_wr_n;
  logic [19:0]  b_addr;
  logic [15:0]  b_din, b_dout;
  logic         b_dout_en, b_ready;
  logic [127:0] b_port_in, b_port_out;

  int checks   = 0;
  int failures = 0;
  int lo_cnt, en_cnt;

  io_port_bank dut_a (
    .CLK(CLK), .RESET(RESET), .ALE(ale), .IOM(iom), .RD_N(rd_n), .WR_N(wr_n),
    .ADDR(addr), .DIN(din), .DOUT(dout), .DOUT_EN(dout_en), .READY(ready),
    .PORT_IN(port_in), .PORT_OUT(port_out)
  );

  io_port_bank #(.DATA_W(16), .NUM_PORTS(8), .WAIT_STATES(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .ALE(b_ale), .IOM(b_iom), .RD_N(b_rd_n), .WR_N(b_wr_n),
    .ADDR(b_addr), .DIN(b_din), .DOUT(b_dout), .DOUT_EN(b_dout_en), .READY(b_ready),
    .PORT_IN(b_port_in), .PORT_OUT(b_port_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete bus cycle on instance a: the strobe is held for 6 edges
  // and then released for 2. READY-low cycles and DOUT_EN-high cycles are counted.
  task automatic cyc(input logic [19:0] a, input logic io, input logic wr, input logic [7:0] d);
    ale = 1'b1; iom = io; addr = a;
    tick();
    ale = 1'b0; iom = 1'b0; din = d;
    if (wr) wr_n = 1'b0; else rd_n = 1'b0;
    lo_cnt = 0; en_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!ready) lo_cnt++;
      if (dout_en) en_cnt++;
    end
    rd_n = 1'b1; wr_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (!ready) lo_cnt++;
      if (dout_en) en_cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b1;
    ale = 0; iom = 0; rd_n = 1; wr_n = 1; addr = '0; din = '0;
    port_in = 32'h113C2233;
    b_ale = 0; b_iom = 0; b_rd_n = 1; b_wr_n = 1; b_addr = '0; b_din = '0;
    b_port_in = 128'h1234 << 80;
    tick(); tick();
    check("rst_ready", ready, 1'b1);
    check("rst_dout_en", dout_en, 1'b0);
    check("rst_dout", dout, 8'h00);
    check("rst_port_out", port_out, 32'h0);
    RESET = 1'b0;
    tick();

    // write 0xA5 to port 2
    ale = 1; iom = 1; addr = 20'h00042;
    tick();
    check("wr_decode_ready", ready, 1'b1);
    ale = 0; iom = 0; wr_n = 0; din = 8'hA5;
    tick(); check("wr_wait1", ready, 1'b0);
    tick(); check("wr_wait2", ready, 1'b0);
    tick(); check("wr_access_ready", ready, 1'b1);
    check("wr_not_yet", port_out, 32'h0);
    tick(); check("wr_port2", port_out, 32'h00A50000);
    wr_n = 1; tick(); tick();

    // read port 2; PORT_IN changes while in DONE
    ale = 1; iom = 1; addr = 20'h00042;
    tick();
    ale = 0; iom = 0; rd_n = 0;
    tick(); check("rd_wait1", ready, 1'b0);
    tick(); tick(); check("rd_access_en", dout_en, 1'b0);
    tick(); check("rd_dout", dout, 8'h3C);
    check("rd_dout_en", dout_en, 1'b1);
    port_in = 32'h11AA2233;
    tick(); tick();
    check("rd_done_hold", dout, 8'h3C);
    check("rd_done_en", dout_en, 1'b1);
    rd_n = 1; tick();
    check("rd_release_en", dout_en, 1'b0);
    check("rd_release_dout", dout, 8'h3C);
    port_in = 32'h113C2233;
    tick();

    // decode boundaries
    cyc(20'h0003F, 1'b1, 1'b1, 8'hEE);
    check("miss_3f_ready", lo_cnt, 0);
    check("miss_3f_port", port_out, 32'h00A50000);
    cyc(20'h00044, 1'b1, 1'b0, 8'h00);
    check("miss_44_ready", lo_cnt, 0);
    check("miss_44_en", en_cnt, 0);
    cyc(20'h00040, 1'b0, 1'b1, 8'hEE);
    check("mem_cycle_ready", lo_cnt, 0);
    check("mem_cycle_port", port_out, 32'h00A50000);
    cyc(20'h00043, 1'b1, 1'b1, 8'h5A);
    check("hit_43_ready", lo_cnt, 2);
    check("hit_43_port", port_out, 32'h5AA50000);
    cyc(20'h00040, 1'b1, 1'b0, 8'h00);
    check("rd_40_dout", dout, 8'h33);
    check("rd_40_en", en_cnt, 3);
    check("rd_40_ready", lo_cnt, 2);

    // abort after one wait cycle
    ale = 1; iom = 1; addr = 20'h00041;
    tick();
    ale = 0; iom = 0; rd_n = 0;
    tick(); check("abort_wait", ready, 1'b0);
    rd_n = 1;
    tick(); check("abort_ready", ready, 1'b1);
    check("abort_en", dout_en, 1'b0);
    tick(); tick();
    check("abort_en_later", dout_en, 1'b0);
    check("abort_dout", dout, 8'h33);

    // both strobes low in DECODE
    ale = 1; iom = 1; addr = 20'h00041;
    tick();
    ale = 0; iom = 0; rd_n = 0; wr_n = 0; din = 8'h77;
    tick(); check("illegal_ready", ready, 1'b1);
    tick(); check("illegal_ready2", ready, 1'b1);
    rd_n = 1; wr_n = 1;
    tick();
    check("illegal_port", port_out, 32'h5AA50000);
    check("illegal_en", dout_en, 1'b0);

    // reset during the WAIT of a write
    ale = 1; iom = 1; addr = 20'h00041;
    tick();
    ale = 0; iom = 0; wr_n = 0; din = 8'hFF;
    tick(); check("rstw_wait", ready, 1'b0);
    RESET = 1;
    tick();
    check("rstw_ready", ready, 1'b1);
    check("rstw_en", dout_en, 1'b0);
    check("rstw_dout", dout, 8'h00);
    check("rstw_port", port_out, 32'h0);
    RESET = 0; wr_n = 1;
    tick(); tick();
    check("rstw_dropped", port_out, 32'h0);
    cyc(20'h00041, 1'b1, 1'b0, 8'h00);
    check("post_rst_dout", dout, 8'h22);
    check("post_rst_en", en_cnt, 3);
    check("post_rst_ready", lo_cnt, 2);

    // instance b: zero wait states, 8 ports of 16 bits
    b_ale = 1; b_iom = 1; b_addr = 20'h00047;
    tick(); check("b_decode_ready", b_ready, 1'b1);
    b_ale = 0; b_iom = 0; b_wr_n = 0; b_din = 16'hBEEF;
    tick(); check("b_access_ready", b_ready, 1'b1);
    check("b_not_yet", b_port_out, 128'h0);
    tick(); check("b_port7", b_port_out, {16'hBEEF, 112'h0});
    check("b_done_ready", b_ready, 1'b1);
    b_wr_n = 1; tick(); tick();
    b_ale = 1; b_iom = 1; b_addr = 20'h00045;
    tick();
    b_ale = 0; b_iom = 0; b_rd_n = 0;
    tick(); check("b_rd_ready", b_ready, 1'b1);
    check("b_rd_en0", b_dout_en, 1'b0);
    tick(); check("b_rd_dout", b_dout, 16'h1234);
    check("b_rd_en1", b_dout_en, 1'b1);
    b_rd_n = 1;
    tick(); check("b_rd_release", b_dout_en, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
